huffman_frame_ctrl: RTL

Frame sequencer in front of the 6-symbol Huffman core.
- Accepts a gray-symbol stream over a valid/ready handshake and feeds exactly FRAME_LEN symbols per frame into the core.
- Waits for the core's code result, captures HC/M into an output holding register and presents it downstream over valid/ready.
- Re-initialises the core between frames and recovers from a hung core with a timeout.

---
 rtl/huffman_frame_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/huffman_frame_ctrl.sv
// rtl/huffman_frame_ctrl.sv - frame sequencer feeding FRAME_LEN symbols per frame into the 6-symbol Huffman core
// Optional feature macro: HUFF_SYMCHK_EN (drop and count symbols outside 1..6).
module huffman_frame_ctrl #(
  parameter int FRAME_LEN = 100,
  parameter int RST_CYC   = 2,
  parameter int TIMEOUT   = 1023,
  parameter int FID_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             core_rst,
  output logic             core_gray_valid,
  output logic [7:0]       core_gray_data,
  input  logic             core_cnt_valid,
  input  logic             core_code_valid,
  input  logic [47:0]      core_hc,
  input  logic [47:0]      core_m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [47:0]      out_hc,
  output logic [47:0]      out_m,
  output logic [FID_W-1:0] out_frame_id,
  output logic             busy,
  output logic             err_timeout,
  output logic [7:0]       sym_err_cnt
);
  localparam int FC_W = $clog2(FRAME_LEN + 1);
  localparam int TM_W = $clog2(TIMEOUT + 1);
  localparam int RC_W = $clog2(RST_CYC + 1);
  localparam logic [FC_W-1:0] FEED_LEN  = FC_W'(FRAME_LEN);
  localparam logic [FC_W-1:0] FEED_LAST = FC_W'(FRAME_LEN - 1);
  localparam logic [TM_W-1:0] TM_LIMIT  = TM_W'(TIMEOUT);
  localparam logic [RC_W-1:0] RC_LAST   = RC_W'(RST_CYC - 1);

  typedef enum logic [1:0] {CORE_RST, FEED, WAIT_CODE, HOLD} state_e;

  state_e            state_q, state_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [FC_W-1:0]   feed_cnt_q, feed_cnt_d;
  logic [TM_W-1:0]   timer_q, timer_d;
  logic              cnt_seen_q, cnt_seen_d;
  logic              gv_q, gv_d;
  logic [7:0]        gd_q, gd_d;
  logic              ov_q, ov_d;
  logic [47:0]       hc_q, hc_d;
  logic [47:0]       m_q, m_d;
  logic [FID_W-1:0]  fid_q, fid_d;
  logic              err_q, err_d;
  logic              xfer, sym_bad, fwd;

  assign xfer = in_valid && in_ready;
`ifdef HUFF_SYMCHK_EN
  assign sym_bad = (in_data == 8'd0) || (in_data > 8'd6);
`else
  assign sym_bad = 1'b0;
`endif
  assign fwd = xfer && !sym_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= CORE_RST;
      rst_cnt_q  <= '0;
      feed_cnt_q <= '0;
      timer_q    <= '0;
      cnt_seen_q <= 1'b0;
      gv_q       <= 1'b0;
      gd_q       <= '0;
      ov_q       <= 1'b0;
      hc_q       <= '0;
      m_q        <= '0;
      fid_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      feed_cnt_q <= feed_cnt_d;
      timer_q    <= timer_d;
      cnt_seen_q <= cnt_seen_d;
      gv_q       <= gv_d;
      gd_q       <= gd_d;
      ov_q       <= ov_d;
      hc_q       <= hc_d;
      m_q        <= m_d;
      fid_q      <= fid_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    feed_cnt_d = feed_cnt_q;
    timer_d    = timer_q;
    cnt_seen_d = cnt_seen_q;
    gv_d       = fwd;
    gd_d       = fwd ? in_data : gd_q;
    ov_d       = ov_q;
    hc_d       = hc_q;
    m_d        = m_q;
    fid_d      = fid_q;
    err_d      = err_q;
    case (state_q)
      CORE_RST: begin
        if (rst_cnt_q == RC_LAST) begin
          state_d   = FEED;
          rst_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end
      FEED: begin
        if (fwd) begin
          feed_cnt_d = feed_cnt_q + FC_W'(1);
          if (feed_cnt_q == FEED_LAST) state_d = WAIT_CODE;
        end
      end
      WAIT_CODE: begin
        timer_d = timer_q + TM_W'(1);
        if (core_cnt_valid) cnt_seen_d = 1'b1;
        // a result arriving on the timeout cycle still wins
        if (core_code_valid) begin
          hc_d    = core_hc;
          m_d     = core_m;
          ov_d    = 1'b1;
          state_d = HOLD;
        end else if (timer_q == TM_LIMIT) begin
          err_d   = 1'b1;
          state_d = CORE_RST;
        end
      end
      HOLD: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          fid_d   = fid_q + FID_W'(1);
          state_d = CORE_RST;
        end
      end
      default: state_d = CORE_RST;
    endcase
    if (state_d == CORE_RST && state_q != CORE_RST) begin
      rst_cnt_d  = '0;
      feed_cnt_d = '0;
      timer_d    = '0;
      cnt_seen_d = 1'b0;
    end
  end

  always_comb begin
    in_ready = 1'b0;
    core_rst = 1'b0;
    busy     = 1'b1;
    case (state_q)
      CORE_RST: core_rst = 1'b1;
      FEED: begin
        in_ready = feed_cnt_q < FEED_LEN;
        busy     = feed_cnt_q != '0;
      end
      default: ;
    endcase
  end

  assign core_gray_valid = gv_q;
  assign core_gray_data  = gd_q;
  assign out_valid       = ov_q;
  assign out_hc          = hc_q;
  assign out_m           = m_q;
  assign out_frame_id    = fid_q;
  assign err_timeout     = err_q;

`ifdef HUFF_SYMCHK_EN
  logic [7:0] sym_err_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sym_err_q <= '0;
    else if (xfer && sym_bad && sym_err_q != 8'hFF) sym_err_q <= sym_err_q + 8'd1;
  end
  assign sym_err_cnt = sym_err_q;
`else
  assign sym_err_cnt = 8'd0;
`endif

  // the core reports its count before its code result
  a_code_after_cnt: assert property (@(posedge clk) disable iff (!reset)
    (state_q == WAIT_CODE && core_code_valid) |-> (cnt_seen_q || core_cnt_valid));

endmodule
